lcd_axis_timing_gen: RTL
========================

// Module: lcd_axis_timing_gen
// PURPOSE
// Parametrised LCD timing generator and AXI4-Stream pixel sink. Successor to the fixed 480x272 LCD driver.
// Consumes the VDMA MM2S stream, already carried into the pixel clock domain by an upstream async FIFO.
// Drives the parallel RGB panel pins and returns lcd_framesync to VDMA mm2s_fsync.
// Adds run-time enable, RGB565/RGB888 input mode, SOF alignment, and underflow/misalignment recovery with status.
// PARAMETERS
// H_ACTIVE  480  visible pixels per line
// H_FP      2    horizontal front porch, pixels
// H_SYNC    41   hsync width, pixels
// H_BP      2    horizontal back porch, pixels
// V_ACTIVE  272  visible lines per frame
// V_FP      2    vertical front porch, lines
// V_SYNC    10   vsync width, lines
// V_BP      2    vertical back porch, lines
// HS_POL    0    hsync active level
// VS_POL    0    vsync active level
// PIX_FMT   0    0 = RGB888 from tdata[23:0]; 1 = RGB565 from tdata[15:0], each field MSB-replicated to 8 bits
// CNT_W     11   counter width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
// lcd_pixel_clk  in   1      pixel clock; the only clock
// rst            in   1      asynchronous reset, active-high
// lcd_en         in   1      1 = run timing; 0 = idle
// underflow_clr  in   1      clears underflow and err_cnt
// axis_tdata     in   32     pixel data
// axis_tvalid    in   1      stream valid
// axis_tready    out  1      stream ready
// axis_tuser     in   1      start of frame (SOF)
// axis_tlast     in   1      end of line (EOL)
// lcd_hs         out  1      horizontal sync
// lcd_vs         out  1      vertical sync
// lcd_de         out  1      display enable
// lcd_rgb        out  24     {R,G,B} pixel
// lcd_framesync  out  1      1-cycle pulse, request next frame
// lcd_xpos       out  CNT_W  active x; 0 outside active area
// lcd_ypos       out  CNT_W  active y; 0 outside active area
// underflow      out  1      sticky; set on underflow or SOF misalignment
// err_cnt        out  16     saturating count of underflow, misaligned-SOF and EOL errors
// BEHAVIOUR
// - Reset values: hs = !HS_POL, vs = !VS_POL; de, rgb, framesync, xpos, ypos, tready, underflow, err_cnt all 0; state IDLE.
// - Counters: h_cnt 0..H_TOTAL-1, H_TOTAL = sum of the H_* parameters; v_cnt steps when h_cnt wraps; V_TOTAL likewise.
// - Region order on both axes: active, front porch, sync, back porch. Sync = POL level inside the sync region.
// - All pin outputs are registered in one stage: 1-cycle latency from counters, and hs/vs/de/rgb/xpos/ypos stay mutually aligned.
// - lcd_framesync pulses when (h_cnt==0, v_cnt==V_ACTIVE), i.e. the first blank line, every frame, in any non-IDLE state.
// - FSM IDLE: counters held at 0, tready=0, syncs inactive. Exits to WAIT_SOF when lcd_en=1.
// - lcd_en=0 in any state: next cycle is IDLE with counters at 0; a frame cut mid-way is not resumed.
// - FSM WAIT_SOF: de still follows timing, rgb=0.
//   - tready=1 while the head beat has tuser=0, so stale beats are flushed.
//   - A tuser=1 head beat is held (tready=0).
//   - At (0,0), if tvalid&&tuser: consume that beat as pixel (0,0) and go to RUN. Otherwise stay in WAIT_SOF.
// - FSM RUN: tready = active-area flag; one beat is consumed per active pixel; rgb=0 outside the active area.
//   - tvalid=0 in active area: underflow. Output rgb=0, set underflow, err_cnt+1, go to WAIT_SOF.
//   - tuser=1 at any active position other than (0,0): misalignment. Beat is not consumed, output rgb=0, set underflow, err_cnt+1, go to WAIT_SOF.
//   - tlast != (x==H_ACTIVE-1): err_cnt+1 only. Beat is consumed and RUN continues.
// - Error-count priority: underflow > SOF misalignment > EOL error. Max +1 per cycle; saturates at 16'hFFFF.
// - underflow_clr in the same cycle as a new error: the error wins. underflow=1, err_cnt=1.
// - RGB565 expansion: R = {d[15:11], d[15:13]}, G = {d[10:5], d[10:9]}, B = {d[4:0], d[4:2]}.
// STRUCTURE
// - Package lcd_timing_pkg: FSM state enum (IDLE, WAIT_SOF, RUN), PIX_FMT_RGB888/PIX_FMT_RGB565 constants,
//   default 480x272 timing constants, rgb565_to_888 function.
// - Sub-module lcd_hv_counter: h/v counters, region decode (active, sync, frame-start, framesync strobe), enable/clear.
// - Top level: FSM, stream handshake, pixel formatting, output register stage, status logic.
// TESTING (timing 8/1/2/1 x 4/1/1/1 -> 12 x 7 totals, polarity 0)
// - Reset, then lcd_en=1 with stream of 32 beats, tuser on beat 0, tlast every 8th -> de high 8 of 12 cycles for 4 lines;
//   rgb equals tdata[23:0] in order; err_cnt=0; framesync once per 84 cycles.
// - 5 stale beats (tuser=0) queued before SOF -> all 5 flushed in WAIT_SOF; first displayed pixel is the SOF beat.
// - tvalid dropped at pixel (3,1) -> rgb=0 from there to end of frame; underflow=1, err_cnt=1;
//   the next SOF is accepted at (0,0) of the following frame.
// - tuser=1 on beat 10 -> rejected at (2,1); underflow=1; recovery at the next frame. tlast on beat 5 -> err_cnt+1, no resync.
// - PIX_FMT=1 with tdata=16'hF81F -> lcd_rgb=24'hFF00FF. Drop lcd_en mid-line -> next cycle hs/vs inactive, de=0, tready=0.
// - rst asserted mid-frame -> all outputs take reset values asynchronously. underflow_clr together with an error -> err_cnt=1.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Shared types, defaults and pixel helpers for the LCD timing generator.
// Default timing matches the original 480x272 panel.
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    RUN      = 2'd2
  } lcd_state_t;

  localparam bit PIX_FMT_RGB888 = 1'b0;
  localparam bit PIX_FMT_RGB565 = 1'b1;

  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_H_SYNC   = 41;
  localparam int DEF_H_BP     = 2;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_V_SYNC   = 10;
  localparam int DEF_V_BP     = 2;
  localparam int DEF_CNT_W    = 11;

  // Each field is widened by repeating its top bits so full-scale stays full-scale.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

endpackage

// File: rtl/lcd_hv_counter.sv
// Horizontal/vertical raster counters with region decode.
// Region order on both axes: active, front porch, sync, back porch.
module lcd_hv_counter
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_active,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_frame_start,
  output logic             o_framesync
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_clr) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;
  assign o_active      = (r_h_cnt < CNT_W'(H_ACTIVE)) && (r_v_cnt < CNT_W'(V_ACTIVE));
  assign o_hsync       = (r_h_cnt >= CNT_W'(HS_START)) && (r_h_cnt < CNT_W'(HS_END));
  assign o_vsync       = (r_v_cnt >= CNT_W'(VS_START)) && (r_v_cnt < CNT_W'(VS_END));
  assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_framesync   = (r_h_cnt == '0) && (r_v_cnt == CNT_W'(V_ACTIVE));

endmodule

// File: rtl/lcd_axis_timing_gen.sv
// LCD timing generator with an AXI4-Stream pixel sink: SOF alignment, underflow
// and misalignment recovery, and a registered pin stage aligned to the counters.
module lcd_axis_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter bit PIX_FMT  = PIX_FMT_RGB888,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             lcd_pixel_clk,
  input  logic             rst,
  input  logic             lcd_en,
  input  logic             underflow_clr,
  input  logic [31:0]      axis_tdata,
  input  logic             axis_tvalid,
  output logic             axis_tready,
  input  logic             axis_tuser,
  input  logic             axis_tlast,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_de,
  output logic [23:0]      lcd_rgb,
  output logic             lcd_framesync,
  output logic [CNT_W-1:0] lcd_xpos,
  output logic [CNT_W-1:0] lcd_ypos,
  output logic             underflow,
  output logic [15:0]      err_cnt
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);

  lcd_state_t       r_state;
  lcd_state_t       w_state_next;
  logic             w_running;
  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_active;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_frame_start;
  logic             w_framesync;
  logic             w_tready;
  logic             w_show;
  logic             w_uf_err;
  logic             w_eol_err;
  logic             w_any_err;
  logic [23:0]      w_pix;
  logic             w_unused_tdata;

  logic             r_hs;
  logic             r_vs;
  logic             r_de;
  logic [23:0]      r_rgb;
  logic             r_framesync;
  logic [CNT_W-1:0] r_xpos;
  logic [CNT_W-1:0] r_ypos;
  logic             r_underflow;
  logic [15:0]      r_err_cnt;

  // Counters idle at the origin whenever the generator is not running.
  assign w_running = lcd_en && (r_state != IDLE);

  lcd_hv_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CNT_W    (CNT_W)
  ) u_hv_counter (
    .i_clk         (lcd_pixel_clk),
    .i_rst         (rst),
    .i_clr         (!w_running),
    .o_h_cnt       (w_h_cnt),
    .o_v_cnt       (w_v_cnt),
    .o_active      (w_active),
    .o_hsync       (w_hsync),
    .o_vsync       (w_vsync),
    .o_frame_start (w_frame_start),
    .o_framesync   (w_framesync)
  );

  generate
    if (PIX_FMT == PIX_FMT_RGB565) begin : g_rgb565
      assign w_pix = rgb565_to_888(axis_tdata[15:0]);
    end else begin : g_rgb888
      assign w_pix = axis_tdata[23:0];
    end
  endgenerate

  assign w_unused_tdata = ^axis_tdata;

  always_ff @(posedge lcd_pixel_clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_tready     = 1'b0;
    w_show       = 1'b0;
    w_uf_err     = 1'b0;
    w_eol_err    = 1'b0;
    if (!lcd_en) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_next = WAIT_SOF;
        WAIT_SOF: begin
          // Flush stale beats; a SOF beat waits at the head until the origin.
          w_tready = w_frame_start || !axis_tuser;
          if (w_frame_start && axis_tvalid && axis_tuser) begin
            w_show       = 1'b1;
            w_state_next = RUN;
          end
        end
        RUN: begin
          if (w_active) begin
            if (!axis_tvalid) begin
              w_tready     = 1'b1;
              w_uf_err     = 1'b1;
              w_state_next = WAIT_SOF;
            end else if (axis_tuser && !w_frame_start) begin
              w_uf_err     = 1'b1;
              w_state_next = WAIT_SOF;
            end else begin
              w_tready  = 1'b1;
              w_show    = 1'b1;
              w_eol_err = axis_tlast != (w_h_cnt == X_LAST);
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign w_any_err   = w_uf_err || w_eol_err;
  assign axis_tready = w_tready;

  always_ff @(posedge lcd_pixel_clk or posedge rst) begin
    if (rst) begin
      r_hs        <= ~HS_POL;
      r_vs        <= ~VS_POL;
      r_de        <= 1'b0;
      r_rgb       <= '0;
      r_framesync <= 1'b0;
      r_xpos      <= '0;
      r_ypos      <= '0;
    end else begin
      r_hs        <= (w_running && w_hsync) ? HS_POL : ~HS_POL;
      r_vs        <= (w_running && w_vsync) ? VS_POL : ~VS_POL;
      r_de        <= w_running && w_active;
      r_rgb       <= w_show ? w_pix : '0;
      r_framesync <= w_running && w_framesync;
      r_xpos      <= (w_running && w_active) ? w_h_cnt : '0;
      r_ypos      <= (w_running && w_active) ? w_v_cnt : '0;
    end
  end

  // A clear arriving with a fresh error keeps that error visible.
  always_ff @(posedge lcd_pixel_clk or posedge rst) begin
    if (rst) begin
      r_underflow <= 1'b0;
      r_err_cnt   <= '0;
    end else if (underflow_clr) begin
      r_underflow <= w_uf_err;
      r_err_cnt   <= w_any_err ? 16'd1 : 16'd0;
    end else begin
      if (w_uf_err) r_underflow <= 1'b1;
      if (w_any_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign lcd_hs        = r_hs;
  assign lcd_vs        = r_vs;
  assign lcd_de        = r_de;
  assign lcd_rgb       = r_rgb;
  assign lcd_framesync = r_framesync;
  assign lcd_xpos      = r_xpos;
  assign lcd_ypos      = r_ypos;
  assign underflow     = r_underflow;
  assign err_cnt       = r_err_cnt;

endmodule
